// File: rtl/if_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package if_prefetch_queue_pkg;

   localparam int INST_W = 32;
   localparam int ADDR_W = 32;

   // Word presented on inst when nothing is buffered.
   localparam logic [INST_W-1:0] NOP_WORD = 32'h0;

   // One buffered fetch result: the instruction and the address following it.
   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [ADDR_W-1:0] pc4;
   } fetch_entry_t;

   // Sequential fetch step; wraps modulo 2^32.
   function automatic logic [ADDR_W-1:0] next_word_addr(input logic [ADDR_W-1:0] a);
      return a + ADDR_W'(4);
   endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Bus bundle between the prefetch queue, instruction memory and IF/ID register.
//
// Handshakes:
//   mem_req/mem_gnt : mem_addr is offered while mem_req=1 and may change freely
//                     until a cycle in which mem_gnt=1; a request is accepted
//                     exactly in a cycle with mem_req & mem_gnt.
//   mem_rvalid      : one word per cycle on mem_rdata, in issue order, no back-pressure.
//   inst_valid/inst_ready : the head entry transfers in a cycle with
//                     inst_valid & inst_ready (and the fetch unit enabled);
//                     inst/inst_pc4 are stable while inst_valid=1 and not taken.
interface if_prefetch_queue_if;
   import if_prefetch_queue_pkg::*;

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [INST_W-1:0] mem_rdata;

   logic              inst_valid;
   logic [INST_W-1:0] inst;
   logic [ADDR_W-1:0] inst_pc4;
   logic              inst_ready;

   // Fetch unit side.
   modport master (
      output mem_req, mem_addr,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output inst_valid, inst, inst_pc4,
      input  inst_ready
   );

   // Memory and decode-stage side.
   modport slave (
      input  mem_req, mem_addr,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  inst_valid, inst, inst_pc4,
      output inst_ready
   );

endinterface

// File: rtl/if_prefetch_queue_sync_fifo.sv
// Small synchronous FIFO with flush and occupancy count.
// Push and pop in the same cycle on a full FIFO both take effect.
// Head data reads as zero when empty.
module sync_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_pop;
   logic             do_push;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_pop  = pop_i & (count_q != '0) & ~flush_i;
   assign do_push = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop) & ~flush_i;

   assign head_o  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Next pointers and occupancy; flush empties the queue outright.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction fetch front end: issues sequential fetches to a variable
// latency memory, buffers returned words with their PC+4, and on a redirect
// flushes the buffer and discards responses still in flight.
module if_prefetch_queue
   import if_prefetch_queue_pkg::*;
#(
   parameter  int                DEPTH    = 4,
   parameter  int                MAX_OUT  = 2,
   parameter  logic [ADDR_W-1:0] RESET_PC = '0,
   localparam int                CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic                   Clk,
   input  logic                   Clrn,
   input  logic                   En,
   input  logic                   redirect,
   input  logic [ADDR_W-1:0]      redirect_pc,
   if_prefetch_queue_if.master    bus,
   output logic [CNT_W-1:0]       dbg_out_cnt_o,
   output logic [CNT_W-1:0]       dbg_disc_cnt_o
);

   localparam int SUM_W     = CNT_W + 1;
   localparam int TAG_CNT_W = $clog2(MAX_OUT + 1);

   logic [ADDR_W-1:0]    fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
   logic [CNT_W-1:0]     disc_cnt_q, disc_cnt_d;

   logic [CNT_W-1:0]     fifo_cnt;
   fetch_entry_t         fifo_head;
   fetch_entry_t         fifo_push_data;
   logic [ADDR_W-1:0]    tag_head;
   logic [TAG_CNT_W-1:0] tag_cnt;

   logic credit_ok;
   logic grant;
   logic rv;
   logic push;
   logic pop;

   // Issue only while both outstanding-request and buffer-space credits allow;
   // words already in flight reserve a slot so a push can never overflow.
   assign credit_ok   = ({1'b0, out_cnt_q} + {1'b0, fifo_cnt}) < SUM_W'(DEPTH);
   assign bus.mem_req = Clrn & En & ~redirect &
                        (out_cnt_q < CNT_W'(MAX_OUT)) & credit_ok;
   assign bus.mem_addr = fetch_pc_q;

   assign grant = bus.mem_req & bus.mem_gnt;
   // A response with no tag outstanding is a protocol error and is ignored.
   assign rv    = bus.mem_rvalid & (tag_cnt != '0);
   // Words belonging to a pre-redirect fetch stream are never buffered.
   assign push  = rv & ~redirect & (disc_cnt_q == '0);
   assign pop   = bus.inst_valid & bus.inst_ready & En & ~redirect;

   assign fifo_push_data = '{inst: bus.mem_rdata, pc4: tag_head};

   assign bus.inst_valid = (fifo_cnt != '0);
   assign bus.inst       = bus.inst_valid ? fifo_head.inst : NOP_WORD;
   assign bus.inst_pc4   = fifo_head.pc4;

   assign dbg_out_cnt_o  = out_cnt_q;
   assign dbg_disc_cnt_o = disc_cnt_q;

   // Buffered {inst, pc4} entries presented to IF/ID.
   sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_inst_fifo (
      .clk_i       (Clk),
      .rst_ni      (Clrn),
      .flush_i     (redirect),
      .push_i      (push),
      .push_data_i (fifo_push_data),
      .pop_i       (pop),
      .head_o      (fifo_head),
      .count_o     (fifo_cnt)
   );

   // PC+4 of each granted request, consumed in order as responses return.
   // Not flushed on redirect: stale responses still need their tag retired.
   sync_fifo #(
      .WIDTH (ADDR_W),
      .DEPTH (MAX_OUT)
   ) u_tag_fifo (
      .clk_i       (Clk),
      .rst_ni      (Clrn),
      .flush_i     (1'b0),
      .push_i      (grant),
      .push_data_i (next_word_addr(fetch_pc_q)),
      .pop_i       (rv),
      .head_o      (tag_head),
      .count_o     (tag_cnt)
   );

   // Next fetch address and in-flight / discard bookkeeping.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      out_cnt_d  = out_cnt_q + CNT_W'(grant) - CNT_W'(rv);
      disc_cnt_d = disc_cnt_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         // Everything still outstanding after this cycle is stale.
         disc_cnt_d = out_cnt_q - CNT_W'(rv);
      end else begin
         if (grant) fetch_pc_d = next_word_addr(fetch_pc_q);
         if (rv && (disc_cnt_q != '0)) disc_cnt_d = disc_cnt_q - CNT_W'(1);
      end
   end

   // Fetch state registers.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         fetch_pc_q <= RESET_PC;
         out_cnt_q  <= '0;
         disc_cnt_q <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         out_cnt_q  <= out_cnt_d;
         disc_cnt_q <= disc_cnt_d;
      end
   end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Testbench for if_prefetch_queue: directed scenarios, a queue-based
// reference model compared every cycle, and literal expectations per scenario.
module tb_if_prefetch_queue;
  import if_prefetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic Clk = 1'b0;
  logic Clrn = 1'b0;
  logic En = 1'b0;
  logic redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [CNT_W-1:0] dbg_out;
  logic [CNT_W-1:0] dbg_disc;

  if_prefetch_queue_if bus ();

  if_prefetch_queue #(
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (RESET_PC)
  ) dut (
    .Clk            (Clk),
    .Clrn           (Clrn),
    .En             (En),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .dbg_out_cnt_o  (dbg_out),
    .dbg_disc_cnt_o (dbg_disc)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] addr; bit stale; } flight_t;
  flight_t m_fl[$];          // granted, not yet returned, in order
  logic [63:0] m_fifo[$];    // {inst, pc4} visible to IF/ID
  logic [31:0] m_pc;

  // ---------------- memory environment ----------------
  typedef struct { logic [31:0] addr; int gcyc; } memreq_t;
  memreq_t mem_q[$];
  int cyc = 0;
  int mem_lat = 1;
  bit spur = 0;

  // Logs of DUT transfers for literal checks.
  logic [31:0] g_log[$];
  logic [31:0] d_log[$];
  logic s_req, s_valid;
  logic [31:0] s_addr, s_pc4;
  logic [CNT_W-1:0] s_out, s_disc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1300_0013;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // One clock cycle: memory drives its response, outputs are compared with
  // the model, then model and memory advance with this cycle's inputs.
  task automatic step();
    bit m_req, m_rv, m_pop;
    int m_disc;
    logic [63:0] exp_head;
    flight_t e;
    @(negedge Clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    if (spur) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = 32'hBAD0_BAD0;
    end else if (mem_q.size() > 0 && mem_q[0].gcyc + mem_lat <= cyc) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = word_of(mem_q[0].addr);
    end
    #1;
    m_req = En && !redirect && (m_fl.size() < MAX_OUT) && (m_fl.size() + m_fifo.size() < DEPTH);
    m_disc = 0;
    foreach (m_fl[i]) if (m_fl[i].stale) m_disc++;
    exp_head = (m_fifo.size() > 0) ? m_fifo[0] : 64'h0;
    chk("mem_req", bus.mem_req, m_req);
    if (m_req) chk("mem_addr", bus.mem_addr, m_pc);
    chk("inst_valid", bus.inst_valid, m_fifo.size() > 0);
    chk("inst", bus.inst, exp_head[63:32]);
    chk("inst_pc4", bus.inst_pc4, exp_head[31:0]);
    chk("out_cnt", dbg_out, m_fl.size());
    chk("disc_cnt", dbg_disc, m_disc);
    s_req = bus.mem_req; s_addr = bus.mem_addr; s_valid = bus.inst_valid;
    s_pc4 = bus.inst_pc4; s_out = dbg_out; s_disc = dbg_disc;
    if (bus.mem_req && bus.mem_gnt) g_log.push_back(bus.mem_addr);
    if (bus.inst_valid && bus.inst_ready && En && !redirect) d_log.push_back(bus.inst_pc4);
    // model advance
    m_rv = bus.mem_rvalid && (m_fl.size() > 0);
    m_pop = (m_fifo.size() > 0) && bus.inst_ready && En && !redirect;
    if (m_pop) void'(m_fifo.pop_front());
    if (m_rv) begin
      e = m_fl.pop_front();
      if (!redirect && !e.stale) m_fifo.push_back({word_of(e.addr), e.addr + 32'd4});
    end
    if (redirect) begin
      m_fifo.delete();
      foreach (m_fl[i]) m_fl[i].stale = 1'b1;
      m_pc = redirect_pc;
    end
    if (m_req && bus.mem_gnt) begin
      m_fl.push_back('{addr: m_pc, stale: 1'b0});
      m_pc = m_pc + 32'd4;
    end
    // memory advance
    if (bus.mem_rvalid && !spur) void'(mem_q.pop_front());
    if (bus.mem_req && bus.mem_gnt) mem_q.push_back('{addr: bus.mem_addr, gcyc: cyc});
    cyc++;
    @(posedge Clk);
    #1;
  endtask

  // Asserts reset away from the clock edge and checks outputs immediately.
  task automatic do_reset();
    @(negedge Clk);
    Clrn = 1'b0;
    #1;
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_inst_valid", bus.inst_valid, 1'b0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_inst_pc4", bus.inst_pc4, 32'h0);
    chk("rst_out_cnt", dbg_out, 0);
    chk("rst_disc_cnt", dbg_disc, 0);
    m_fl.delete();
    m_fifo.delete();
    m_pc = RESET_PC;
    mem_q.delete();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(posedge Clk);
    #1;
    Clrn = 1'b1;
    g_log.delete();
    d_log.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    bus.mem_gnt = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    bus.inst_ready = 1'b1;
    En = 1'b1;

    // 1: streaming with 1-cycle memory, then En low absorbs responses
    mem_lat = 1;
    do_reset();
    repeat (6) step();
    chk("t1_g0", at(g_log, 0), 32'h0);
    chk("t1_g1", at(g_log, 1), 32'h4);
    chk("t1_g2", at(g_log, 2), 32'h8);
    chk("t1_d0", at(d_log, 0), 32'h4);
    chk("t1_d1", at(d_log, 1), 32'h8);
    chk("t1_d2", at(d_log, 2), 32'hC);
    En = 1'b0;
    step();
    chk("t1_en_req", s_req, 1'b0);
    repeat (2) step();
    En = 1'b1;
    repeat (4) step();

    // 2: IF/ID stalled for 10 cycles
    do_reset();
    bus.inst_ready = 1'b0;
    repeat (10) step();
    chk("t2_req_off", s_req, 1'b0);
    chk("t2_valid", s_valid, 1'b1);
    chk("t2_head", s_pc4, 32'h4);
    chk("t2_out0", s_out, 0);
    bus.inst_ready = 1'b1;
    repeat (8) step();
    chk("t2_d0", at(d_log, 0), 32'h4);
    chk("t2_d1", at(d_log, 1), 32'h8);
    chk("t2_d2", at(d_log, 2), 32'hC);
    chk("t2_d3", at(d_log, 3), 32'h10);
    chk("t2_d4", at(d_log, 4), 32'h14);
    chk("t2_g4", at(g_log, 4), 32'h10);

    // 3: redirect with two outstanding and two buffered
    do_reset();
    mem_lat = 3;
    bus.inst_ready = 1'b0;
    repeat (6) step();
    redirect = 1'b1;
    redirect_pc = 32'h40;
    step();
    chk("t3_out2", s_out, 2);
    chk("t3_head", s_pc4, 32'h4);
    chk("t3_noreq", s_req, 1'b0);
    redirect = 1'b0;
    step();
    chk("t3_flushed", s_valid, 1'b0);
    chk("t3_disc2", s_disc, 2);
    bus.inst_ready = 1'b1;
    repeat (10) step();
    chk("t3_g4", at(g_log, 4), 32'h40);
    chk("t3_d0", at(d_log, 0), 32'h44);

    // 4: redirect coincident with a response
    do_reset();
    mem_lat = 2;
    repeat (2) step();
    redirect = 1'b1;
    redirect_pc = 32'h80;
    step();
    chk("t4_out2", s_out, 2);
    redirect = 1'b0;
    step();
    chk("t4_disc1", s_disc, 1);
    chk("t4_out1", s_out, 1);
    repeat (8) step();
    chk("t4_g2", at(g_log, 2), 32'h80);
    chk("t4_d0", at(d_log, 0), 32'h84);
    chk("t4_d1", at(d_log, 1), 32'h88);

    // 5: grant withheld, spurious response, redirect, then grant
    do_reset();
    mem_lat = 1;
    bus.mem_gnt = 1'b0;
    repeat (2) step();
    spur = 1'b1;
    step();
    spur = 1'b0;
    repeat (2) step();
    chk("t5_req_wait", s_req, 1'b1);
    chk("t5_addr_wait", s_addr, 32'h0);
    chk("t5_out0", s_out, 0);
    redirect = 1'b1;
    redirect_pc = 32'hC0;
    step();
    chk("t5_req_redir", s_req, 1'b0);
    redirect = 1'b0;
    bus.mem_gnt = 1'b1;
    step();
    chk("t5_addr_new", s_addr, 32'hC0);
    repeat (6) step();
    chk("t5_g0", at(g_log, 0), 32'hC0);
    chk("t5_d0", at(d_log, 0), 32'hC4);

    // 6: reset pulsed mid-stream
    do_reset();
    repeat (7) step();
    do_reset();
    repeat (4) step();
    chk("t6_g0", at(g_log, 0), RESET_PC);
    chk("t6_d0", at(d_log, 0), RESET_PC + 32'h4);

    // 7: fetch address wrap
    do_reset();
    step();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    repeat (8) step();
    chk("t7_g1", at(g_log, 1), 32'hFFFF_FFF8);
    chk("t7_g3", at(g_log, 3), 32'h0);
    chk("t7_d0", at(d_log, 0), 32'hFFFF_FFFC);
    chk("t7_d1", at(d_log, 1), 32'h0);
    chk("t7_d2", at(d_log, 2), 32'h4);

    // 8: back-to-back redirects
    do_reset();
    mem_lat = 3;
    repeat (2) step();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    step();
    chk("t8_disc1", s_disc, 1);
    repeat (10) step();
    chk("t8_g2", at(g_log, 2), 32'h200);
    chk("t8_d0", at(d_log, 0), 32'h204);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
